// File: rtl/phy_mem_ctrl.sv
// Physical memory controller: turns dev_mem word accesses into timed strobes on two async 32-bit SRAM banks.
// Optional single-entry read buffer is built when PHY_MEM_RDBUF_EN is defined.
module phy_mem_ctrl #(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned RAM_AWIDTH  = 20
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           dev_mem_addr,
   input  logic [31:0]           dev_mem_data_out,
   input  logic                  dev_mem_is_write,
   input  logic                  opt_is_lw,
   output logic [31:0]           dev_mem_data_in,
   output logic                  dev_mem_busy,
   output logic [RAM_AWIDTH-1:0] sram_addr,
   output logic [31:0]           sram_dq_out,
   input  logic [31:0]           sram_dq_in,
   output logic                  sram_dq_oe,
   output logic [1:0]            sram_ce_n,
   output logic                  sram_oe_n,
   output logic                  sram_we_n,
   output logic                  addr_err
);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

   state_t                state_q;
   logic [3:0]            wait_q;
   logic [29:0]           addr_q;
   logic [31:0]           data_q;
   logic                  is_write_q;
   logic                  in_range_q;
   logic [31:0]           rdata_q;
   logic [RAM_AWIDTH-1:0] sram_addr_q;
   logic [31:0]           dq_out_q;
   logic                  dq_oe_q;
   logic [1:0]            ce_n_q;
   logic                  oe_n_q;
   logic                  we_n_q;
   logic                  addr_err_q;

   logic       req_in_range;
   logic [1:0] req_ce_n;
   logic       req_match;

   assign req_in_range = (dev_mem_addr[31:23] == 9'd0);
   assign req_ce_n     = !req_in_range ? 2'b11 : (dev_mem_addr[22] ? 2'b01 : 2'b10);

   // The core may have moved on while the SRAM cycle ran; only an unchanged request completes.
   assign req_match = (dev_mem_addr[31:2] == addr_q) && (dev_mem_is_write == is_write_q)
                   && (!is_write_q || (dev_mem_data_out == data_q));

`ifdef PHY_MEM_RDBUF_EN
   logic        buf_valid_q;
   logic [29:0] buf_addr_q;
   logic [31:0] buf_data_q;
   logic        buf_hit;
   logic [1:0]  unused_addr;

   assign buf_hit     = !dev_mem_is_write && !opt_is_lw && buf_valid_q
                     && (buf_addr_q == dev_mem_addr[31:2]);
   assign unused_addr = dev_mem_addr[1:0];
`else
   logic [2:0]  unused_in;

   assign unused_in = {opt_is_lw, dev_mem_addr[1:0]};
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         wait_q      <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         is_write_q  <= 1'b0;
         in_range_q  <= 1'b0;
         rdata_q     <= '0;
         sram_addr_q <= '0;
         dq_out_q    <= '0;
         dq_oe_q     <= 1'b0;
         ce_n_q      <= 2'b11;
         oe_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         addr_err_q  <= 1'b0;
`ifdef PHY_MEM_RDBUF_EN
         // NOTE: only the valid bit needs reset; buffer data is never used while invalid.
         buf_valid_q <= 1'b0;
         buf_addr_q  <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               addr_q     <= dev_mem_addr[31:2];
               data_q     <= dev_mem_data_out;
               is_write_q <= dev_mem_is_write;
               in_range_q <= req_in_range;
`ifdef PHY_MEM_RDBUF_EN
               if (buf_hit) begin
                  rdata_q <= buf_data_q;
                  state_q <= DONE;
               end else
`endif
               begin
                  sram_addr_q <= dev_mem_addr[RAM_AWIDTH+1:2];
                  ce_n_q      <= req_ce_n;
                  dq_oe_q     <= dev_mem_is_write;
                  if (dev_mem_is_write) begin
                     dq_out_q <= dev_mem_data_out;
                  end
                  state_q <= SETUP;
               end
            end
            SETUP: begin
               wait_q  <= WAIT_LOAD;
               oe_n_q  <= ~(~is_write_q & in_range_q);
               we_n_q  <= ~(is_write_q & in_range_q);
               state_q <= STROBE;
            end
            STROBE: begin
               if (wait_q == 4'd0) begin
                  oe_n_q     <= 1'b1;
                  we_n_q     <= 1'b1;
                  addr_err_q <= ~in_range_q;
                  if (!is_write_q) begin
                     rdata_q <= in_range_q ? sram_dq_in : 32'd0;
                  end
`ifdef PHY_MEM_RDBUF_EN
                  if (!is_write_q && in_range_q) begin
                     buf_valid_q <= 1'b1;
                     buf_addr_q  <= addr_q;
                     buf_data_q  <= sram_dq_in;
                  end else if (is_write_q && buf_valid_q && (buf_addr_q == addr_q)) begin
                     buf_data_q <= data_q;
                  end
`endif
                  state_q <= DONE;
               end else begin
                  wait_q <= wait_q - 4'd1;
               end
            end
            DONE: begin
               // Chip enables and write data were held through DONE for write hold time.
               addr_err_q <= 1'b0;
               ce_n_q     <= 2'b11;
               dq_oe_q    <= 1'b0;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dev_mem_busy    = !((state_q == DONE) && req_match);
   assign dev_mem_data_in = rdata_q;
   assign sram_addr       = sram_addr_q;
   assign sram_dq_out     = dq_out_q;
   assign sram_dq_oe      = dq_oe_q;
   assign sram_ce_n       = ce_n_q;
   assign sram_oe_n       = oe_n_q;
   assign sram_we_n       = we_n_q;
   assign addr_err        = addr_err_q;

endmodule
